// File: rtl/mcp3008_responder.sv
// SPI responder that behaves like an MCP3008 10-bit ADC on the slave side of the bus.
// SCLK/CS_n/DIN are oversampled in the clk domain; every output is registered.
module mcp3008_responder #(
  parameter int N        = 10,
  parameter int CHANNELS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS_n,
  input  logic                  DIN,
  output logic                  DOUT,
  output logic                  DOUT_en,
  input  logic [CHANNELS*N-1:0] chan_data,
  output logic                  conv_valid,
  output logic [2:0]            conv_ch,
  output logic                  conv_diff,
  output logic                  busy
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    SAMPLE     = 3'd3,
    NULLB      = 3'd4,
    DATA       = 3'd5,
    TAIL       = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sclk_sync_q;
  logic [2:0]       cs_sync_q;
  logic [1:0]       din_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [N-1:0]     shift_q, shift_d;
  logic             dout_q, dout_d;
  logic             dout_en_q, dout_en_d;
  logic             busy_q, busy_d;
  logic             conv_valid_q, conv_valid_d;
  logic [2:0]       conv_ch_q, conv_ch_d;
  logic             conv_diff_q, conv_diff_d;

  logic             sclk_rise_s, sclk_fall_s, cs_rise_s, cs_low_s, din_s;
  logic [N-1:0]     ch_val_s [CHANNELS];
  logic [N-1:0]     pos_s, neg_s, sample_s;
  logic [N:0]       diff_s;

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      din_sync_q  <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      cs_sync_q   <= {cs_sync_q[1:0], CS_n};
      din_sync_q  <= {din_sync_q[0], DIN};
    end
  end

  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_low_s    = ~cs_sync_q[1];
  assign din_s       = din_sync_q[1];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch_val_s[k] = chan_data[k*N +: N];
  end

  // IN+ is always the addressed channel and IN- its pair partner, so D0 swaps the roles.
  always_comb begin
    pos_s  = ch_val_s[cmd_q[2:0]];
    neg_s  = ch_val_s[cmd_q[2:0] ^ 3'b001];
    diff_s = {1'b0, pos_s} - {1'b0, neg_s};
    if (cmd_q[3]) begin
      sample_s = pos_s;
    end else if (!diff_s[N]) begin
      sample_s = diff_s[N-1:0];
    end else begin
      sample_s = {N{1'b0}};
    end
  end

  // Frame sequencer: next state and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_en_d    = dout_en_q;
    busy_d       = busy_q;
    conv_valid_d = 1'b0;
    conv_ch_d    = conv_ch_q;
    conv_diff_d  = conv_diff_q;
    if (cs_rise_s) begin
      state_d   = IDLE;
      cnt_d     = CNT_ZERO;
      cmd_d     = 4'b0000;
      dout_d    = 1'b0;
      dout_en_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dout_d    = 1'b0;
          dout_en_d = 1'b0;
          busy_d    = 1'b0;
          if (cs_low_s) begin
            state_d = WAIT_START;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_START: begin
          if (sclk_rise_s && din_s) begin
            state_d = CMD;
            busy_d  = 1'b1;
            cnt_d   = CNT_ZERO;
            cmd_d   = 4'b0000;
          end else begin
            state_d = WAIT_START;
          end
        end
        CMD: begin
          if (sclk_rise_s) begin
            cmd_d = {cmd_q[2:0], din_s};
            if (cnt_q == CMD_LAST) begin
              state_d   = SAMPLE;
              dout_en_d = 1'b1;
              cnt_d     = CNT_ZERO;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = CMD;
          end
        end
        SAMPLE: begin
          if (sclk_rise_s) begin
            shift_d      = sample_s;
            conv_valid_d = 1'b1;
            conv_ch_d    = cmd_q[2:0];
            conv_diff_d  = ~cmd_q[3];
            state_d      = NULLB;
          end else begin
            state_d = SAMPLE;
          end
        end
        NULLB: begin
          if (sclk_fall_s) begin
            dout_d  = 1'b0;
            cnt_d   = CNT_ZERO;
            state_d = DATA;
          end else begin
            state_d = NULLB;
          end
        end
        DATA: begin
          if (sclk_fall_s) begin
            dout_d  = shift_q[N-1];
            shift_d = {shift_q[N-2:0], 1'b0};
            if (cnt_q == DATA_LAST) begin
              state_d = TAIL;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = DATA;
          end
        end
        TAIL: begin
          if (sclk_fall_s) begin
            dout_d = 1'b0;
          end else begin
            dout_d = dout_q;
          end
        end
        default: begin
          state_d   = IDLE;
          dout_d    = 1'b0;
          dout_en_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      cmd_q        <= 4'b0000;
      shift_q      <= {N{1'b0}};
      dout_q       <= 1'b0;
      dout_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_ch_q    <= 3'b000;
      conv_diff_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      busy_q       <= busy_d;
      conv_valid_q <= conv_valid_d;
      conv_ch_q    <= conv_ch_d;
      conv_diff_q  <= conv_diff_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_en    = dout_en_q;
  assign busy       = busy_q;
  assign conv_valid = conv_valid_q;
  assign conv_ch    = conv_ch_q;
  assign conv_diff  = conv_diff_q;

endmodule
